// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage:
// opcodes, PSR bit positions, FSM states.
package cpu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_CMP = 4'd6;
    localparam logic [3:0] OP_LSH = 4'd7;

    localparam int PSR_C = 0;
    localparam int PSR_Z = 1;
    localparam int PSR_F = 2;
    localparam int PSR_L = 3;
    localparam int PSR_N = 4;

    localparam int AMTBITS = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } execState_e;

    // Magnitude of a signed shift amount; -16 maps to 16.
    function automatic logic [AMTBITS-1:0] absAmt(
        input logic [AMTBITS-1:0] amt
    );
        return amt[AMTBITS-1] ? (~amt + 1'b1) : amt;
    endfunction

endpackage

// File: rtl/exec_shifter.sv
// Iterative 1-bit/cycle logical shifter.
// done flags the cycle whose edge performs the last step.
module exec_shifter
    import cpu_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [AMTBITS-1:0] amount,
    input  logic [SIZE-1:0]    dataIn,
    output logic               done,
    output logic [SIZE-1:0]    result
);

    logic [SIZE-1:0]    shReg;
    logic [AMTBITS-1:0] count;
    logic               left;

    assign result = left ? {shReg[SIZE-2:0], 1'b0}
                         : {1'b0, shReg[SIZE-1:1]};
    assign done   = (count == AMTBITS'(1));

    // Load operand and |amount|, then shift once per cycle until empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shReg <= '0;
            count <= '0;
            left  <= 1'b0;
        end else if (start) begin
            shReg <= dataIn;
            count <= absAmt(amount);
            left  <= ~amount[AMTBITS-1];
        end else if (count != '0) begin
            shReg <= result;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: ALU, PSR flags, register-file
// write port, with an iterative LSH path.
module exec_stage
    import cpu_pkg::*;
#(
    parameter int SIZE    = 16,
    parameter int REGBITS = 4,
    parameter int IMMBITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inValid,
    output logic               inReady,
    input  logic [3:0]         opcode,
    input  logic               useImm,
    input  logic [IMMBITS-1:0] imm,
    input  logic [SIZE-1:0]    srcData,
    input  logic [SIZE-1:0]    dstData,
    input  logic [REGBITS-1:0] dstAddrIn,
    output logic               writeEn,
    output logic [SIZE-1:0]    writeData,
    output logic [REGBITS-1:0] wrAddr,
    output logic [4:0]         psr
);

    execState_e         state;
    execState_e         stateNext;
    logic               started;
    logic               accept;
    logic               zeroExt;
    logic [SIZE-1:0]    extImm;
    logic [SIZE-1:0]    opA;
    logic [SIZE-1:0]    opB;
    logic [SIZE:0]      sum;
    logic [SIZE:0]      diff;
    logic [SIZE-1:0]    aluResult;
    logic               aluWrite;
    logic [4:0]         psrNext;
    logic [AMTBITS-1:0] amt;
    logic               shStart;
    logic               shDone;
    logic [SIZE-1:0]    shResult;
    logic [REGBITS-1:0] lshAddr;

    assign zeroExt = (opcode == OP_AND) || (opcode == OP_OR)
                  || (opcode == OP_XOR);
    assign extImm  = zeroExt
        ? {{(SIZE-IMMBITS){1'b0}}, imm}
        : {{(SIZE-IMMBITS){imm[IMMBITS-1]}}, imm};
    assign opA     = dstData;
    assign opB     = useImm ? extImm : srcData;
    assign sum     = {1'b0, opA} + {1'b0, opB};
    assign diff    = {1'b0, opA} - {1'b0, opB};
    assign amt     = opB[AMTBITS-1:0];
    assign inReady = started && (state != ST_SHIFT);
    assign accept  = inValid && inReady;
    assign shStart = accept && (opcode == OP_LSH) && (amt != '0);

    exec_shifter #(
        .SIZE (SIZE)
    ) uShifter (
        .clk    (clk),
        .reset  (reset),
        .start  (shStart),
        .amount (amt),
        .dataIn (opA),
        .done   (shDone),
        .result (shResult)
    );

    // Single-cycle result, write request and flag update.
    always_comb begin
        aluResult = '0;
        aluWrite  = 1'b0;
        psrNext   = psr;
        case (opcode)
            OP_ADD: begin
                aluResult      = sum[SIZE-1:0];
                aluWrite       = 1'b1;
                psrNext[PSR_C] = sum[SIZE];
                psrNext[PSR_F] = (opA[SIZE-1] == opB[SIZE-1])
                              && (sum[SIZE-1] != opA[SIZE-1]);
            end
            OP_SUB: begin
                aluResult      = diff[SIZE-1:0];
                aluWrite       = 1'b1;
                psrNext[PSR_C] = diff[SIZE];
                psrNext[PSR_F] = (opA[SIZE-1] != opB[SIZE-1])
                              && (diff[SIZE-1] != opA[SIZE-1]);
            end
            OP_AND: begin
                aluResult = opA & opB;
                aluWrite  = 1'b1;
            end
            OP_OR: begin
                aluResult = opA | opB;
                aluWrite  = 1'b1;
            end
            OP_XOR: begin
                aluResult = opA ^ opB;
                aluWrite  = 1'b1;
            end
            OP_MOV: begin
                aluResult = opB;
                aluWrite  = 1'b1;
            end
            OP_CMP: begin
                psrNext[PSR_Z] = (opA == opB);
                psrNext[PSR_L] = (opA < opB);
                psrNext[PSR_N] = ($signed(opA) < $signed(opB));
            end
            OP_LSH: begin
                aluResult = opA;
                aluWrite  = (amt == '0);
            end
            default: begin
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= stateNext;
    end

    // FSM next state: DONE behaves like IDLE for new accepts.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE,
            ST_DONE:  stateNext = shStart ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: if (shDone) stateNext = ST_DONE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    // Hold inReady low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) started <= 1'b0;
        else        started <= 1'b1;
    end

    // Output registers: one-cycle write strobe, PSR update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            writeEn   <= 1'b0;
            writeData <= '0;
            wrAddr    <= '0;
            psr       <= '0;
            lshAddr   <= '0;
        end else begin
            writeEn <= 1'b0;
            if (accept) begin
                psr <= psrNext;
                if (shStart) lshAddr <= dstAddrIn;
                if (aluWrite) begin
                    writeEn   <= 1'b1;
                    writeData <= aluResult;
                    wrAddr    <= dstAddrIn;
                end
            end
            if ((state == ST_SHIFT) && shDone) begin
                writeEn   <= 1'b1;
                writeData <= shResult;
                wrAddr    <= lshAddr;
            end
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage:
// vector table plus multi-cycle LSH/reset sequences.
module tb_exec_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [3:0]  opcode = 4'd0;
    logic        useImm = 1'b0;
    logic [7:0]  imm = 8'd0;
    logic [15:0] srcData = 16'd0;
    logic [15:0] dstData = 16'd0;
    logic [3:0]  dstAddrIn = 4'd0;
    logic        writeEn;
    logic [15:0] writeData;
    logic [3:0]  wrAddr;
    logic [4:0]  psr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exec_stage #(
        .SIZE    (16),
        .REGBITS (4),
        .IMMBITS (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .inValid   (inValid),
        .inReady   (inReady),
        .opcode    (opcode),
        .useImm    (useImm),
        .imm       (imm),
        .srcData   (srcData),
        .dstData   (dstData),
        .dstAddrIn (dstAddrIn),
        .writeEn   (writeEn),
        .writeData (writeData),
        .wrAddr    (wrAddr),
        .psr       (psr)
    );

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic        ui;
        logic [7:0]  im;
        logic [15:0] src;
        logic [15:0] dst;
        logic [3:0]  addr;
        logic        we;
        logic [15:0] data;
        logic [4:0]  psr;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op,
                         input logic ui, input logic [7:0] im,
                         input logic [15:0] s, input logic [15:0] d,
                         input logic [3:0] a);
        inValid   = v;
        opcode    = op;
        useImm    = ui;
        imm       = im;
        srcData   = s;
        dstData   = d;
        dstAddrIn = a;
    endtask

    task automatic runLsh(input string name, input logic [15:0] d,
                          input logic [15:0] s, input logic ui,
                          input logic [7:0] im, input logic [3:0] a,
                          input logic [15:0] expData, input int expLat);
        int n;
        int low;
        drive(1'b1, OP_LSH, ui, im, s, d, a);
        step();
        inValid = 1'b0;
        n = 1;
        low = 0;
        while (writeEn !== 1'b1 && n < 40) begin
            if (inReady === 1'b0) low++;
            step();
            n++;
        end
        chk({name, "_latency"}, n, expLat);
        chk({name, "_stallcycles"}, low, expLat - 1);
        chk({name, "_data"}, writeData, expData);
        chk({name, "_addr"}, wrAddr, a);
        chk({name, "_readyDone"}, inReady, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int weSeen;
        //        v     op      ui    imm    src       dst       a     we    data      psr
        vecs[0]  = '{1'b1, OP_ADD, 1'b0, 8'h00, 16'h0001, 16'h7FFF, 4'd1, 1'b1, 16'h8000, 5'b00100};
        vecs[1]  = '{1'b1, OP_ADD, 1'b0, 8'h00, 16'h0001, 16'hFFFF, 4'd2, 1'b1, 16'h0000, 5'b00001};
        vecs[2]  = '{1'b1, OP_CMP, 1'b1, 8'hFF, 16'h0000, 16'h0005, 4'd3, 1'b0, 16'h0000, 5'b01001};
        vecs[3]  = '{1'b1, OP_AND, 1'b1, 8'h80, 16'h0000, 16'hFFFF, 4'd3, 1'b1, 16'h0080, 5'b01001};
        vecs[4]  = '{1'b1, OP_ADD, 1'b1, 8'h80, 16'h0000, 16'h0001, 4'd4, 1'b1, 16'hFF81, 5'b01000};
        vecs[5]  = '{1'b1, OP_SUB, 1'b0, 8'h00, 16'h0005, 16'h0003, 4'd5, 1'b1, 16'hFFFE, 5'b01001};
        vecs[6]  = '{1'b1, OP_SUB, 1'b0, 8'h00, 16'h0001, 16'h8000, 4'd6, 1'b1, 16'h7FFF, 5'b01100};
        vecs[7]  = '{1'b1, OP_OR,  1'b1, 8'h0F, 16'h0000, 16'h00F0, 4'd7, 1'b1, 16'h00FF, 5'b01100};
        vecs[8]  = '{1'b1, OP_XOR, 1'b0, 8'h00, 16'h00FF, 16'hFFFF, 4'd8, 1'b1, 16'hFF00, 5'b01100};
        vecs[9]  = '{1'b1, OP_MOV, 1'b1, 8'h80, 16'h1234, 16'h0000, 4'd9, 1'b1, 16'hFF80, 5'b01100};
        vecs[10] = '{1'b1, OP_CMP, 1'b0, 8'h00, 16'h0001, 16'h8000, 4'd0, 1'b0, 16'h0000, 5'b10100};
        vecs[11] = '{1'b1, OP_CMP, 1'b0, 8'h00, 16'h1234, 16'h1234, 4'd0, 1'b0, 16'h0000, 5'b00110};
        vecs[12] = '{1'b1, 4'd9,   1'b0, 8'h00, 16'h0001, 16'h0001, 4'hA, 1'b0, 16'h0000, 5'b00110};
        vecs[13] = '{1'b1, OP_LSH, 1'b0, 8'h00, 16'h0000, 16'hABCD, 4'hB, 1'b1, 16'hABCD, 5'b00110};
        vecs[14] = '{1'b0, OP_ADD, 1'b0, 8'h00, 16'h0001, 16'h0001, 4'hC, 1'b0, 16'h0000, 5'b00110};
        vecs[15] = '{1'b1, OP_SUB, 1'b1, 8'h01, 16'h0000, 16'h0000, 4'hD, 1'b1, 16'hFFFF, 5'b00011};

        // Power-on reset with an op presented.
        drive(1'b1, OP_ADD, 1'b0, 8'h00, 16'h0001, 16'h0001, 4'd5);
        step();
        step();
        chk("rst_writeEn", writeEn, 1'b0);
        chk("rst_writeData", writeData, 16'h0000);
        chk("rst_wrAddr", wrAddr, 4'h0);
        chk("rst_psr", psr, 5'b00000);
        chk("rst_inReady", inReady, 1'b0);
        reset = 1'b1;
        #1;
        chk("rel_inReady_before_edge", inReady, 1'b0);
        step();
        chk("rel_inReady", inReady, 1'b1);
        chk("rel_writeEn", writeEn, 1'b0);

        // Single-cycle vector table, back-to-back.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].ui, vecs[i].im,
                  vecs[i].src, vecs[i].dst, vecs[i].addr);
            step();
            chk($sformatf("vec%0d_writeEn", i), writeEn, vecs[i].we);
            if (vecs[i].we) begin
                chk($sformatf("vec%0d_data", i), writeData, vecs[i].data);
                chk($sformatf("vec%0d_addr", i), wrAddr, vecs[i].addr);
            end
            chk($sformatf("vec%0d_psr", i), psr, vecs[i].psr);
            chk($sformatf("vec%0d_ready", i), inReady, 1'b1);
        end

        // Reset asserted mid-stream.
        drive(1'b1, OP_ADD, 1'b0, 8'h00, 16'h0001, 16'h7FFF, 4'd3);
        step();
        chk("mid_pre_writeEn", writeEn, 1'b1);
        reset = 1'b0;
        #1;
        chk("mid_writeEn", writeEn, 1'b0);
        chk("mid_writeData", writeData, 16'h0000);
        chk("mid_wrAddr", wrAddr, 4'h0);
        chk("mid_psr", psr, 5'b00000);
        chk("mid_inReady", inReady, 1'b0);
        step();
        inValid = 1'b0;
        reset = 1'b1;
        step();
        chk("mid_rel_inReady", inReady, 1'b1);

        // LSH +4, then an op accepted in the DONE cycle.
        runLsh("lsh_p4", 16'h0001, 16'h0004, 1'b0, 8'h00, 4'd5,
               16'h0010, 5);
        drive(1'b1, OP_ADD, 1'b0, 8'h00, 16'h0003, 16'h0002, 4'd6);
        step();
        inValid = 1'b0;
        chk("done_accept_writeEn", writeEn, 1'b1);
        chk("done_accept_data", writeData, 16'h0005);
        chk("done_accept_addr", wrAddr, 4'd6);
        step();
        chk("done_accept_strobe_off", writeEn, 1'b0);

        runLsh("lsh_m16", 16'hFFFF, 16'h0010, 1'b0, 8'h00, 4'd7,
               16'h0000, 17);
        runLsh("lsh_m3imm", 16'h0080, 16'h0000, 1'b1, 8'hFD, 4'd8,
               16'h0010, 4);
        runLsh("lsh_p15", 16'h8001, 16'h000F, 1'b0, 8'h00, 4'd9,
               16'h8000, 16);
        chk("lsh_psr_kept", psr, 5'b00000);

        // LSH by 8 aborted by reset in cycle 3.
        drive(1'b1, OP_ADD, 1'b0, 8'h00, 16'h0001, 16'hFFFF, 4'd1);
        step();
        chk("abort_pre_psr", psr, 5'b00001);
        drive(1'b1, OP_LSH, 1'b0, 8'h00, 16'h0008, 16'h0001, 4'd9);
        step();
        inValid = 1'b0;
        chk("abort_busy", inReady, 1'b0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("abort_writeEn", writeEn, 1'b0);
        chk("abort_inReady", inReady, 1'b0);
        chk("abort_psr", psr, 5'b00000);
        step();
        reset = 1'b1;
        step();
        chk("abort_idle_ready", inReady, 1'b1);
        weSeen = 0;
        for (int c = 0; c < 12; c++) begin
            if (writeEn === 1'b1) weSeen++;
            step();
        end
        chk("abort_no_write", weSeen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
